// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes them into
// instruction memory. The core is held on NOP_WORD until a load completes.
module imem_boot_loader #(
   parameter int          DEPTH    = 128,
   parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [7:0]  i_len_words,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte,
   output logic        o_byte_ready,
   output logic        o_we,
   output logic [6:0]  o_waddr,
   output logic [31:0] o_wdata,
   input  logic [31:0] i_mem_rd,
   output logic [31:0] o_fetch_rd,
   output logic        o_core_hold,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  len_q, len_d;
   logic [6:0]  wcnt_q, wcnt_d;
   logic [1:0]  bidx_q, bidx_d;
   logic [31:0] asm_q, asm_d;
   logic        err_q, err_d;
   logic        len_ok;

   assign len_ok = (i_len_words != 8'd0) && ({24'd0, i_len_words} <= 32'(DEPTH));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         len_q   <= 8'd0;
         wcnt_q  <= 7'd0;
         bidx_q  <= 2'd0;
         asm_q   <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         wcnt_q  <= wcnt_d;
         bidx_q  <= bidx_d;
         asm_q   <= asm_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      wcnt_d  = wcnt_q;
      bidx_d  = bidx_q;
      asm_d   = asm_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               if (len_ok) begin
                  state_d = S_LOAD;
                  len_d   = i_len_words;
                  wcnt_d  = 7'd0;
                  bidx_d  = 2'd0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (i_byte_valid) begin
               asm_d[{bidx_q, 3'b000} +: 8] = i_byte;
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            // len_q is at least 1, so the subtraction cannot underflow
            if ({1'b0, wcnt_q} == len_q - 8'd1) begin
               state_d = S_DONE;
            end else begin
               wcnt_d  = wcnt_q + 7'd1;
               state_d = S_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_byte_ready = (state_q == S_LOAD);
   assign o_we         = (state_q == S_WRITE);
   assign o_waddr      = wcnt_q;
   assign o_wdata      = asm_q;
   assign o_busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
   assign o_done       = (state_q == S_DONE);
   assign o_core_hold  = (state_q != S_DONE);
   assign o_err        = err_q;
   assign o_fetch_rd   = o_core_hold ? NOP_WORD : i_mem_rd;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: writes are logged at the falling edge and checked per scenario.
module tb_imem_boot_loader;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_start;
   logic [7:0]  i_len_words;
   logic        i_byte_valid;
   logic [7:0]  i_byte;
   logic        o_byte_ready;
   logic        o_we;
   logic [6:0]  o_waddr;
   logic [31:0] o_wdata;
   logic [31:0] i_mem_rd;
   logic [31:0] o_fetch_rd;
   logic        o_core_hold;
   logic        o_busy;
   logic        o_done;
   logic        o_err;

   int errors = 0;
   int checks = 0;

   int          we_cnt = 0;
   int          rdy_bad = 0;
   logic [6:0]  wa [0:255];
   logic [31:0] wd [0:255];

   always #5 i_clk = ~i_clk;

   imem_boot_loader dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len_words(i_len_words),
      .i_byte_valid(i_byte_valid), .i_byte(i_byte), .o_byte_ready(o_byte_ready),
      .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata), .i_mem_rd(i_mem_rd),
      .o_fetch_rd(o_fetch_rd), .o_core_hold(o_core_hold), .o_busy(o_busy),
      .o_done(o_done), .o_err(o_err)
   );

   always @(negedge i_clk) begin
      if (o_we === 1'b1) begin
         if (we_cnt < 256) begin
            wa[we_cnt] = o_waddr;
            wd[we_cnt] = o_wdata;
         end
         we_cnt++;
         if (o_byte_ready !== 1'b0) rdy_bad++;
      end
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic apply_reset();
      i_rst = 1'b1;
      step();
      step();
      i_rst = 1'b0;
      step();
   endtask

   task automatic start_load(input logic [7:0] len);
      i_start     = 1'b1;
      i_len_words = len;
      step();
      i_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      i_byte_valid = 1'b0;
      repeat (gap) step();
      i_byte_valid = 1'b1;
      i_byte       = b;
      n = 0;
      while (o_byte_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) begin
         errors++;
         checks++;
         $display("FAIL byte_ready_timeout: o_byte_ready=%b, required 1 within 20 cycles", o_byte_ready);
      end
      step();
      i_byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      send_byte(w[7:0], gap);
      send_byte(w[15:8], gap);
      send_byte(w[23:16], gap);
      send_byte(w[31:24], gap);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (o_done !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (o_done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: o_done=%b, required 1", o_done);
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_start = 1'b0; i_len_words = 8'd0; i_byte_valid = 1'b0;
      i_byte = 8'd0; i_mem_rd = 32'hFFFF_FFFF;
      #1;
      checks++;
      if ({o_we, o_byte_ready, o_busy, o_done, o_err, o_core_hold} !== 6'b000001) begin
         errors++;
         $display("FAIL reset_outputs: we,rdy,busy,done,err,hold=%b, required 000001",
                  {o_we, o_byte_ready, o_busy, o_done, o_err, o_core_hold});
      end
      checks++;
      if (o_fetch_rd !== 32'h0000_0013) begin
         errors++;
         $display("FAIL reset_fetch: o_fetch_rd=%h, required 00000013", o_fetch_rd);
      end
      step();
      i_rst = 1'b0;
      step();
   endtask

   task automatic test_one_word();
      int base;
      base = we_cnt;
      start_load(8'd1);
      checks++;
      if ({o_busy, o_byte_ready, o_core_hold} !== 3'b111) begin
         errors++;
         $display("FAIL one_load_state: busy,rdy,hold=%b, required 111", {o_busy, o_byte_ready, o_core_hold});
      end
      send_word(32'h0000_0013, 0);
      checks++;
      if (o_we !== 1'b1 || o_waddr !== 7'd0 || o_wdata !== 32'h0000_0013 || o_byte_ready !== 1'b0) begin
         errors++;
         $display("FAIL one_write: we=%b addr=%0d data=%h rdy=%b, required 1 0 00000013 0",
                  o_we, o_waddr, o_wdata, o_byte_ready);
      end
      step();
      checks++;
      if ({o_done, o_core_hold, o_busy, o_we} !== 4'b1000) begin
         errors++;
         $display("FAIL one_done: done,hold,busy,we=%b, required 1000", {o_done, o_core_hold, o_busy, o_we});
      end
      i_mem_rd = 32'hCAFE_F00D;
      #1;
      checks++;
      if (o_fetch_rd !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL one_fetch: o_fetch_rd=%h, required cafef00d", o_fetch_rd);
      end
      checks++;
      if (we_cnt - base !== 1) begin
         errors++;
         $display("FAIL one_we_count: writes=%0d, required 1", we_cnt - base);
      end
   endtask

   task automatic test_err();
      int base;
      base = we_cnt;
      // illegal start while DONE: pulse only, DONE kept
      start_load(8'd0);
      checks++;
      if ({o_err, o_done, o_core_hold, o_busy} !== 4'b1100) begin
         errors++;
         $display("FAIL err_in_done: err,done,hold,busy=%b, required 1100", {o_err, o_done, o_core_hold, o_busy});
      end
      step();
      checks++;
      if ({o_err, o_done} !== 2'b01) begin
         errors++;
         $display("FAIL err_in_done_pulse: err,done=%b, required 01", {o_err, o_done});
      end
      apply_reset();
      start_load(8'd0);
      checks++;
      if ({o_err, o_busy, o_core_hold, o_done} !== 4'b1010) begin
         errors++;
         $display("FAIL err_len0: err,busy,hold,done=%b, required 1010", {o_err, o_busy, o_core_hold, o_done});
      end
      step();
      checks++;
      if (o_err !== 1'b0) begin
         errors++;
         $display("FAIL err_len0_pulse: o_err=%b, required 0", o_err);
      end
      start_load(8'd129);
      checks++;
      if ({o_err, o_busy, o_byte_ready} !== 3'b100) begin
         errors++;
         $display("FAIL err_len129: err,busy,rdy=%b, required 100", {o_err, o_busy, o_byte_ready});
      end
      step();
      step();
      checks++;
      if (o_err !== 1'b0 || we_cnt != base) begin
         errors++;
         $display("FAIL err_len129_after: err=%b writes=%0d, required 0 0", o_err, we_cnt - base);
      end
   endtask

   task automatic test_gaps();
      int base;
      logic [31:0] exp_w [0:2];
      exp_w[0] = 32'h1122_3344;
      exp_w[1] = 32'hA5A5_5A5A;
      exp_w[2] = 32'h0BAD_F00D;
      base = we_cnt;
      rdy_bad = 0;
      start_load(8'd3);
      send_word(exp_w[0], 0);
      step();
      checks++;
      if (o_byte_ready !== 1'b1 || o_we !== 1'b0) begin
         errors++;
         $display("FAIL gap_latency: rdy=%b we=%b two cycles after 4th byte, required 1 0", o_byte_ready, o_we);
      end
      for (int k = 0; k < 4; k++) send_byte(exp_w[1][k*8 +: 8], (k * 3) % 4);
      for (int k = 0; k < 4; k++) send_byte(exp_w[2][k*8 +: 8], (k + 2) % 3);
      wait_done();
      step();
      checks++;
      if (we_cnt - base !== 3) begin
         errors++;
         $display("FAIL gap_count: writes=%0d, required 3", we_cnt - base);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (wa[base + i] !== 7'(i) || wd[base + i] !== exp_w[i]) begin
            errors++;
            $display("FAIL gap_word%0d: addr=%0d data=%h, required %0d %h", i, wa[base + i], wd[base + i], i, exp_w[i]);
         end
      end
      checks++;
      if (rdy_bad !== 0) begin
         errors++;
         $display("FAIL gap_rdy_in_write: cycles=%0d, required 0", rdy_bad);
      end
   endtask

   task automatic test_restart();
      int base;
      base = we_cnt;
      start_load(8'd2);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      i_start = 1'b1;
      i_len_words = 8'd1;
      step();
      i_start = 1'b0;
      step();
      checks++;
      if (o_err !== 1'b0 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL restart_ignored: err=%b busy=%b, required 0 1", o_err, o_busy);
      end
      send_byte(8'h03, 0);
      send_byte(8'h04, 0);
      step();
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL restart_len_kept: done=%b busy=%b after word 0, required 0 1", o_done, o_busy);
      end
      send_word(32'h8877_6655, 1);
      wait_done();
      checks++;
      if (we_cnt - base !== 2 || wd[base] !== 32'h0403_0201 || wd[base + 1] !== 32'h8877_6655) begin
         errors++;
         $display("FAIL restart_writes: n=%0d d0=%h d1=%h, required 2 04030201 88776655",
                  we_cnt - base, wd[base], wd[base + 1]);
      end
      start_load(8'd1);
      checks++;
      if ({o_done, o_core_hold, o_busy, o_err} !== 4'b0110) begin
         errors++;
         $display("FAIL reload_from_done: done,hold,busy,err=%b, required 0110", {o_done, o_core_hold, o_busy, o_err});
      end
      send_word(32'h0000_0013, 0);
      wait_done();
   endtask

   task automatic test_reset_mid();
      int base;
      apply_reset();
      base = we_cnt;
      start_load(8'd2);
      send_word(32'h0403_0201, 0);
      send_byte(8'h05, 0);
      send_byte(8'h06, 0);
      i_mem_rd = 32'h1234_5678;
      i_rst = 1'b1;
      #1;
      checks++;
      if ({o_we, o_byte_ready, o_busy, o_done, o_err, o_core_hold} !== 6'b000001) begin
         errors++;
         $display("FAIL midreset_outputs: we,rdy,busy,done,err,hold=%b, required 000001",
                  {o_we, o_byte_ready, o_busy, o_done, o_err, o_core_hold});
      end
      checks++;
      if (o_fetch_rd !== 32'h0000_0013) begin
         errors++;
         $display("FAIL midreset_fetch: o_fetch_rd=%h, required 00000013", o_fetch_rd);
      end
      step();
      i_rst = 1'b0;
      repeat (4) step();
      checks++;
      if ({o_core_hold, o_done, o_busy} !== 3'b100) begin
         errors++;
         $display("FAIL midreset_after: hold,done,busy=%b, required 100", {o_core_hold, o_done, o_busy});
      end
      checks++;
      if (we_cnt - base !== 1 || wa[base] !== 7'd0 || wd[base] !== 32'h0403_0201) begin
         errors++;
         $display("FAIL midreset_writes: n=%0d addr=%0d data=%h, required 1 0 04030201",
                  we_cnt - base, wa[base], wd[base]);
      end
   endtask

   task automatic test_full_depth();
      int base;
      int bad;
      base = we_cnt;
      bad = 0;
      start_load(8'd128);
      for (int i = 0; i < 128; i++) send_word({8'h3C, ~8'(i), 8'hA0, 8'(i)}, 0);
      wait_done();
      checks++;
      if (we_cnt - base !== 128) begin
         errors++;
         $display("FAIL full_count: writes=%0d, required 128", we_cnt - base);
      end
      for (int i = 0; i < 128; i++) begin
         if (wa[base + i] !== 7'(i) || wd[base + i] !== {8'h3C, ~8'(i), 8'hA0, 8'(i)}) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL full_data: bad_words=%0d, required 0", bad);
      end
      checks++;
      if (wa[base + 127] !== 7'd127) begin
         errors++;
         $display("FAIL full_last_addr: addr=%0d, required 127", wa[base + 127]);
      end
      i_mem_rd = 32'h00C0_FFEE;
      #1;
      checks++;
      if (o_fetch_rd !== 32'h00C0_FFEE || o_core_hold !== 1'b0) begin
         errors++;
         $display("FAIL full_fetch: fetch=%h hold=%b, required 00c0ffee 0", o_fetch_rd, o_core_hold);
      end
   endtask

   initial begin
      test_reset();
      test_one_word();
      test_err();
      test_gaps();
      test_restart();
      test_reset_mid();
      test_full_depth();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
